instr_fetch: RTL and testbench

- Instruction fetch unit: the producer end of the opcode interface the main control decoder consumes.
- Keeps the PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them with their PC and opcode field to the decode stage over a valid/ready handshake.
- Handles one-cycle redirects (branch/jump): flushes the buffer and discards any in-flight memory response.

---
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: PC, req/ack instruction-memory reads, small FIFO toward decode, redirect/drain handling.
// Optional INSTR_FETCH_PERF_EN adds perf_fetch_o / perf_stall_o counters.
module instr_fetch #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [5:0]  op_o,
   output logic [31:0] pc_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
`ifdef INSTR_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_o,
   output logic [31:0] perf_stall_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [31:0]        pc;
   logic [31:0]        pc_nxt;
   logic [31:0]        drain_addr;
   logic [31:0]        drain_addr_nxt;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [31:0]        mem_pc   [DEPTH];
   logic [31:0]        mem_inst [DEPTH];

   logic               req;
   logic               accept;
   logic               valid;
   logic               push;
   logic               pop;
   logic [31:0]        target_pc;
   logic               redirect_pc_unused;

   assign target_pc          = {redirect_pc_i[31:2], 2'b00};
   assign redirect_pc_unused = ^redirect_pc_i[1:0];

   // Request depends only on registered state, so it cannot combinationally follow ack.
   assign req    = ((state == S_FETCH) && (count < CNT_W'(DEPTH))) || (state == S_DRAIN);
   assign accept = req & imem_ack_i;
   assign valid  = (count != '0);
   assign push   = (state == S_FETCH) && accept && !redirect_i;
   assign pop    = valid && inst_ready_i && !redirect_i;

   assign imem_req_o   = req;
   assign imem_addr_o  = (state == S_DRAIN) ? drain_addr : pc;
   assign inst_valid_o = valid;
   assign inst_o       = valid ? mem_inst[rd_ptr] : 32'h0;
   assign pc_o         = valid ? mem_pc[rd_ptr]   : 32'h0;
   assign op_o         = inst_o[31:26];

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      drain_addr_nxt = drain_addr;
      case (state)
         S_IDLE: begin
            if (redirect_i) begin
               pc_nxt = target_pc;
            end else if (start_i) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (redirect_i) begin
               pc_nxt = target_pc;
               // An unanswered request must still be completed; park its address while draining.
               if (req && !imem_ack_i) begin
                  state_nxt      = S_DRAIN;
                  drain_addr_nxt = pc;
               end
            end else if (push) begin
               pc_nxt = pc + 32'd4;
            end
         end
         S_DRAIN: begin
            if (redirect_i) begin
               pc_nxt = target_pc;
            end
            if (imem_ack_i) begin
               state_nxt = S_FETCH;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         drain_addr <= drain_addr_nxt;
         if (redirect_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_pc[wr_ptr]   <= pc;
         mem_inst[wr_ptr] <= imem_data_i;
      end
   end

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_fetch <= 32'h0;
         perf_stall <= 32'h0;
      end else begin
         if (push) begin
            perf_fetch <= perf_fetch + 32'd1;
         end
         if ((state != S_IDLE) && !valid) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end

   assign perf_fetch_o = perf_fetch;
   assign perf_stall_o = perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for instr_fetch: table of traffic phases driven against a PC/FIFO scoreboard model.
module tb_instr_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, start, imem_req, imem_ack, inst_valid, inst_ready, redirect;
   logic [31:0] imem_addr, imem_data, inst, pc, redirect_pc;
   logic [5:0]  op;
`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] perf_fetch, perf_stall;
`endif

   always #5 clk = ~clk;

   instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (imem_ack),
      .imem_data_i  (imem_data),
      .inst_valid_o (inst_valid),
      .inst_ready_i (inst_ready),
      .inst_o       (inst),
      .op_o         (op),
      .pc_o         (pc),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc)
`ifdef INSTR_FETCH_PERF_EN
      ,
      .perf_fetch_o (perf_fetch),
      .perf_stall_o (perf_stall)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } sb_t;

   typedef struct {
      int          cycles;
      int          lat;
      bit          rdy;
      bit          start;
      int          redir_at;
      logic [31:0] rpc;
      int          exp_acc;
      int          exp_del;
   } phase_t;

   sb_t         exp_q[$];
   phase_t      ph[11];
   int          checks = 0;
   int          passed = 0;

   logic [31:0] exp_pc;
   logic [31:0] drain_addr;
   bit          started;
   bit          discard;
   int          wcnt;
   int          pushes;
   int          stalls;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_pc     = RESET_PC;
      drain_addr = RESET_PC;
      started    = 0;
      discard    = 0;
      wcnt       = 0;
      pushes     = 0;
      stalls     = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; start = 0; imem_ack = 0; inst_ready = 0; redirect = 0;
      redirect_pc = 32'h0; imem_data = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
      chk("rst_req",   {31'h0, imem_req},   32'h0);
      chk("rst_addr",  imem_addr,           RESET_PC);
      chk("rst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_inst",  inst,                32'h0);
      chk("rst_pc",    pc,                  32'h0);
      chk("rst_op",    {26'h0, op},         32'h0);
`ifdef INSTR_FETCH_PERF_EN
      chk("rst_perf_fetch", perf_fetch, 32'h0);
      chk("rst_perf_stall", perf_stall, 32'h0);
`endif
   endtask

   task automatic run_phase(input int idx);
      phase_t p;
      int     acc, del;
      bit     exp_req, exp_valid, ack;
      sb_t    e;
      p   = ph[idx];
      acc = 0;
      del = 0;
      for (int c = 0; c < p.cycles; c++) begin
         @(negedge clk);
         exp_req   = started && (discard || (exp_q.size() < DEPTH));
         exp_valid = (exp_q.size() != 0);
         chk("req",   {31'h0, imem_req},   {31'h0, exp_req});
         chk("valid", {31'h0, inst_valid}, {31'h0, exp_valid});
         if (exp_req) chk("addr", imem_addr, discard ? drain_addr : exp_pc);

         // Memory model: answer after p.lat waiting cycles.
         ack = imem_req && (wcnt >= p.lat);
         if (!imem_req)   wcnt = 0;
         else if (ack)    wcnt = 0;
         else             wcnt++;
         imem_ack    = ack;
         imem_data   = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
         inst_ready  = p.rdy;
         redirect    = (c == p.redir_at);
         redirect_pc = p.rpc;
         start       = p.start && (c == 0);

         if (started && !exp_valid) stalls++;
         if (redirect) begin
            if (started && exp_req && !ack) begin
               if (!discard) drain_addr = exp_pc;
               discard = 1;
            end else begin
               discard = 0;
            end
            exp_pc = p.rpc & ~32'h3;
            exp_q.delete();
         end else begin
            if (exp_valid && inst_ready) begin
               e = exp_q.pop_front();
               chk("head_pc",   pc,            e.pc);
               chk("head_inst", inst,          e.data);
               chk("head_op",   {26'h0, op},   {26'h0, e.data[31:26]});
               del++;
            end
            if (exp_req && ack) begin
               if (discard) begin
                  discard = 0;
               end else begin
                  exp_q.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
                  exp_pc = exp_pc + 32'd4;
                  acc++;
                  pushes++;
               end
            end
            if (start && !started) started = 1;
         end
      end
      chk($sformatf("phase%0d_accepts", idx),    acc, p.exp_acc);
      chk($sformatf("phase%0d_deliveries", idx), del, p.exp_del);
   endtask

   task automatic perf_check();
`ifdef INSTR_FETCH_PERF_EN
      @(negedge clk);
      chk("perf_fetch", perf_fetch, pushes);
      chk("perf_stall", perf_stall, stalls);
      // Hold the FIFO quiet for the sampling cycle so the model stays aligned.
      if (started && exp_q.size() == 0) stalls++;
`endif
   endtask

   initial begin
      rst = 1; start = 0; imem_ack = 0; inst_ready = 0; redirect = 0;
      redirect_pc = 32'h0; imem_data = 32'h0;

      //          cycles lat rdy start redir rpc           acc del
      ph[0]  = '{8,  0, 1, 1, -1, 32'h0,          7, 6};  // start, single-cycle acks
      ph[1]  = '{6,  0, 0, 0, -1, 32'h0,          1, 0};  // backpressure fills FIFO
      ph[2]  = '{4,  0, 1, 0, -1, 32'h0,          3, 4};  // release, request resumes
      ph[3]  = '{10, 3, 1, 0, -1, 32'h0,          2, 3};  // late acks
      ph[4]  = '{8,  3, 1, 0, 0,  32'h0000_0103,  1, 1};  // redirect while pending -> drain
      ph[5]  = '{6,  0, 1, 0, 3,  32'h0000_0200,  5, 3};  // redirect with ack and pop
      ph[6]  = '{5,  0, 1, 0, 0,  32'hFFFF_FFF8,  4, 3};  // PC wrap
      ph[7]  = '{1,  2, 1, 0, 0,  32'h0000_0300,  0, 0};  // enter drain
      ph[8]  = '{8,  2, 1, 0, 0,  32'h0000_0400,  2, 1};  // second redirect during drain
      ph[9]  = '{6,  0, 0, 1, -1, 32'h0,          2, 0};  // fresh start, stalled decode
      ph[10] = '{3,  0, 1, 0, -1, 32'h0,          2, 3};  // drain heads 0x0, 0x4

      do_reset();
      for (int i = 0; i <= 8; i++) run_phase(i);
      // Perf sampling cycle drives idle inputs; avoid disturbing the DUT.
      imem_ack = 0; inst_ready = 0; redirect = 0; start = 0;
      perf_check();
      do_reset();
      for (int i = 9; i <= 10; i++) run_phase(i);
      imem_ack = 0; inst_ready = 0; redirect = 0; start = 0;
      perf_check();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
